// File: rtl/sdr_sram_pkg.sv
// Shared definitions for the sdr_sram_pipe block: FSM encoding and read-latency bounds.
// Optional parity storage is enabled by the SDR_SRAM_PARITY_EN macro in sdr_sram_pipe.
package sdr_sram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 4;

  // Out-of-range latencies collapse to the nearest legal value.
  function automatic int unsigned clamp_latency(input int unsigned lat);
    if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
    if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/sram_rsp_pipe.sv
// Fixed-depth valid/data shift pipeline with synchronous active-low clear.
// Data of an invalid slot is forced to zero so the output is quiet between strobes.
module sram_rsp_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Shift one slot per cycle; clear discards everything in flight.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/sdr_sram_pipe.sv
// Single-port lane-masked SRAM with post-reset clear and fixed read latency.
// Define SDR_SRAM_PARITY_EN to add per-lane even parity storage, ReqParityFlip
// and RspParityErr.
module sdr_sram_pipe
  import sdr_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned LANE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                             Clock,
  input  logic                             ResetN,
  input  logic                             ReqValid,
  output logic                             ReqReady,
  input  logic                             ReqWrite,
  input  logic [ADDR_WIDTH-1:0]            ReqAddress,
  input  logic [DATA_WIDTH-1:0]            ReqData,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] ReqMask,
  output logic                             RspValid,
  output logic [DATA_WIDTH-1:0]            RspData,
  output logic                             InitDone
`ifdef SDR_SRAM_PARITY_EN
  ,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] ReqParityFlip,
  output logic [DATA_WIDTH/LANE_WIDTH-1:0] RspParityErr
`endif
);

  localparam int unsigned LANES      = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned WORDS      = 1 << ADDR_WIDTH;
  // One extra stage holds the array read taken at the accepting edge.
  localparam int unsigned PIPE_DEPTH = clamp_latency(READ_LATENCY) + 1;
`ifdef SDR_SRAM_PARITY_EN
  localparam int unsigned PAY_W      = DATA_WIDTH + LANES;
`else
  localparam int unsigned PAY_W      = DATA_WIDTH;
`endif

  state_e                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    wr_en, rd_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [LANES-1:0]        wr_mask;
  logic [DATA_WIDTH-1:0]   mem [WORDS];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [PAY_W-1:0]        rd_payload, rsp_payload;
`ifdef SDR_SRAM_PARITY_EN
  logic [LANES-1:0]        wr_flip;
  logic [LANES-1:0]        par_mem [WORDS];
  logic [LANES-1:0]        rd_err;
`endif

  // State register and clear counter.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end
  end

  // Next state and array port steering: INIT owns the write port until the last word is zeroed.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wr_addr    = ReqAddress;
    wr_data    = ReqData;
    wr_mask    = ReqMask;
`ifdef SDR_SRAM_PARITY_EN
    wr_flip    = ReqParityFlip;
`endif
    case (state)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = '0;
        wr_mask = '1;
`ifdef SDR_SRAM_PARITY_EN
        wr_flip = '0;
`endif
        if (&clr_cnt) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (ReqValid) begin
          wr_en = ReqWrite;
          rd_en = !ReqWrite;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign ReqReady = (state == ST_RUN);
  assign InitDone = (state == ST_RUN);

  // Lane-masked array write, shared by the clear sweep and user writes.
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_mask[l]) begin
          mem[wr_addr][l*LANE_WIDTH +: LANE_WIDTH] <= wr_data[l*LANE_WIDTH +: LANE_WIDTH];
`ifdef SDR_SRAM_PARITY_EN
          par_mem[wr_addr][l] <= (^wr_data[l*LANE_WIDTH +: LANE_WIDTH]) ^ wr_flip[l];
`endif
        end
      end
    end
  end

  // Array read sampled by the first pipe stage at the accepting edge, before any later write lands.
  always_comb begin
    rd_word = mem[ReqAddress];
`ifdef SDR_SRAM_PARITY_EN
    rd_err = '0;
    for (int l = 0; l < LANES; l++) begin
      rd_err[l] = (^rd_word[l*LANE_WIDTH +: LANE_WIDTH]) ^ par_mem[ReqAddress][l];
    end
    rd_payload = {rd_err, rd_word};
`else
    rd_payload = rd_word;
`endif
  end

  sram_rsp_pipe #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH (PAY_W)
  ) u_rsp_pipe (
    .clk       (Clock),
    .clear_n   (ResetN),
    .in_valid  (rd_en),
    .in_data   (rd_payload),
    .out_valid (RspValid),
    .out_data  (rsp_payload)
  );

  assign RspData = rsp_payload[DATA_WIDTH-1:0];
`ifdef SDR_SRAM_PARITY_EN
  assign RspParityErr = rsp_payload[PAY_W-1:DATA_WIDTH];
`endif

endmodule
